cr16_flag_tracer: RTL

Parametrised successor to the CR16 processor bring-up fixture. It generates a stretched reset for the processor core and records the ALU flag vector (C, L, F, Z, N) into an on-chip circular trace buffer. The buffer captures on a mask/value trigger with configurable post-trigger depth and is read back through a pop interface. It sits beside the processor top level, drives the core's reset, and observes its flag outputs every cycle.

---
 rtl/cr16_flag_tracer_if.sv | 31 +++
 rtl/cr16_flag_tracer.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/cr16_flag_tracer_if.sv
// Bus bundle between the CR16 flag tracer and its host: flag observation, capture
// control, pop interface and status.
interface cr16_flag_tracer_if #(
  parameter int unsigned FLAG_W = 5,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned TS_W   = 16
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [FLAG_W-1:0]      Flags;
  logic                   Arm;
  logic                   Mode;
  logic [FLAG_W-1:0]      TrigMask;
  logic [FLAG_W-1:0]      TrigValue;
  logic                   RdEn;
  logic                   CpuReset;
  logic [TS_W+FLAG_W-1:0] RdData;
  logic                   RdValid;
  logic [CntW-1:0]        Count;
  logic                   Done;

  modport master (
    output Flags, Arm, Mode, TrigMask, TrigValue, RdEn,
    input  CpuReset, RdData, RdValid, Count, Done
  );

  modport slave (
    input  Flags, Arm, Mode, TrigMask, TrigValue, RdEn,
    output CpuReset, RdData, RdValid, Count, Done
  );
endinterface

// File: rtl/cr16_flag_tracer.sv
// CR16 bring-up fixture: stretched core reset plus a triggered circular trace of the
// ALU flag vector {C,L,F,Z,N}, read back oldest-first through a pop port.
module cr16_flag_tracer #(
  parameter int unsigned FLAG_W     = 5,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned POST       = 8,
  parameter int unsigned RST_CYCLES = 3,
  parameter int unsigned TS_W       = 16
) (
  input logic              Clk,
  input logic              Reset,
  cr16_flag_tracer_if.slave bus
);
  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned BootW = $clog2(RST_CYCLES + 1);
  localparam int unsigned EntW  = TS_W + FLAG_W;

  localparam logic [BootW-1:0] BootLast = BootW'(RST_CYCLES);
  localparam logic [PtrW-1:0]  PostLast = PtrW'((POST == 0) ? 0 : POST - 1);
  localparam logic [CntW-1:0]  CntFull  = CntW'(DEPTH);

  typedef enum logic [2:0] {StBoot, StIdle, StPre, StPostT, StDone} state_e;

  state_e state_q, state_d;

  logic [BootW-1:0]  boot_cnt_q, boot_cnt_d;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [PtrW-1:0]   post_cnt_q, post_cnt_d;
  logic [FLAG_W-1:0] last_q, last_d;
  logic              first_q, first_d;
  logic              mode_q, mode_d;
  logic [FLAG_W-1:0] mask_q, mask_d;
  logic [FLAG_W-1:0] value_q, value_d;
  logic              done_q, done_d;
  logic              rd_valid_q, rd_valid_d;
  logic [EntW-1:0]   rd_data_q, rd_data_d;

  logic [EntW-1:0]   mem_q [DEPTH];

  logic arm_ok, sampling, trig_hit, store, post_last, pop, boot_done;

  always_comb begin
    arm_ok    = bus.Arm && (state_q != StBoot);
    sampling  = (state_q == StPre) || (state_q == StPostT);
    trig_hit  = (state_q == StPre) && (((bus.Flags ^ value_q) & mask_q) == '0);
    // The trigger sample is stored even when Mode 1 would drop it as unchanged.
    store     = sampling && !arm_ok &&
                (trig_hit || !mode_q || first_q || (bus.Flags != last_q));
    post_last = (state_q == StPostT) && store && (post_cnt_q == PostLast);
    // Re-arm wins over a coincident pop since it discards the buffer anyway.
    pop       = done_q && bus.RdEn && !bus.Arm && (count_q != '0);
    boot_done = (state_q == StBoot) && (boot_cnt_q == BootLast);
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (!Reset) state_q <= StBoot;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBoot:         if (boot_done) state_d = StIdle;
      StIdle, StDone: if (bus.Arm) state_d = StPre;
      StPre: begin
        if (bus.Arm)       state_d = StPre;
        else if (trig_hit) state_d = (POST == 0) ? StDone : StPostT;
      end
      StPostT: begin
        if (bus.Arm)        state_d = StPre;
        else if (post_last) state_d = StDone;
      end
      default: state_d = StBoot;
    endcase
  end

  // Outputs.
  always_comb begin
    bus.CpuReset = (state_q == StBoot);
    bus.Done     = done_q;
    bus.RdValid  = rd_valid_q;
    bus.RdData   = rd_data_q;
    bus.Count    = count_q;
  end

  // Datapath next-state.
  always_comb begin
    boot_cnt_d = boot_cnt_q;
    ts_d       = ts_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    post_cnt_d = post_cnt_q;
    last_d     = last_q;
    first_d    = first_q;
    mode_d     = mode_q;
    mask_d     = mask_q;
    value_d    = value_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = pop;
    // Done lags DONE entry by one cycle so the final write has settled before readout.
    done_d     = (state_q == StDone) && (state_d == StDone);

    if ((state_q == StBoot) && !boot_done) boot_cnt_d = boot_cnt_q + BootW'(1);

    if (arm_ok) begin
      ts_d       = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      post_cnt_d = '0;
      first_d    = 1'b1;
      mode_d     = bus.Mode;
      mask_d     = bus.TrigMask;
      value_d    = bus.TrigValue;
    end else if (sampling) begin
      ts_d    = ts_q + TS_W'(1);
      first_d = 1'b0;
      if (store) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
        last_d   = bus.Flags;
        if (count_q == CntFull) rd_ptr_d = rd_ptr_q + PtrW'(1);
        else                    count_d  = count_q + CntW'(1);
        if (state_q == StPostT) post_cnt_d = post_cnt_q + PtrW'(1);
      end
    end

    if (pop) begin
      rd_data_d = mem_q[rd_ptr_q];
      rd_ptr_d  = rd_ptr_q + PtrW'(1);
      count_d   = count_q - CntW'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      boot_cnt_q <= '0;
      ts_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      post_cnt_q <= '0;
      last_q     <= '0;
      first_q    <= 1'b0;
      mode_q     <= 1'b0;
      mask_q     <= '0;
      value_q    <= '0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      boot_cnt_q <= boot_cnt_d;
      ts_q       <= ts_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      post_cnt_q <= post_cnt_d;
      last_q     <= last_d;
      first_q    <= first_d;
      mode_q     <= mode_d;
      mask_q     <= mask_d;
      value_q    <= value_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Trace storage needs no reset; Count bounds what is ever read.
  always_ff @(posedge Clk) begin
    if (store) mem_q[wr_ptr_q] <= {ts_q, bus.Flags};
  end
endmodule
